// File: rtl/lsm_sequencer.sv
// lsm_sequencer: Load-Multiple / Store-Multiple sequencer beside decode.
// Walks a latched register list in ascending index order, one memory beat
// per set bit, and holds fetch/decode stalled until the transfer ends.
// Optional macro LSM_BASE_WRITEBACK_EN: write base_addr+beats back to the
// base register in FINISH (suppressed for LM when the base was loaded).
//
//   state  | meaning
//   IDLE   | waiting for start; start_ready high
//   RUN    | issuing one beat per cycle while mem_ready is high
//   FINISH | one-cycle done pulse (and optional base writeback)
module lsm_sequencer #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              start_ready,
  input  logic              is_store,
  input  logic [REG_AW-1:0] base_reg,
  input  logic [DATA_W-1:0] base_addr,
  input  logic [NREGS-1:0]  reg_list,
  input  logic              flush,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [REG_AW-1:0] reg_rd_addr,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic              reg_wr_en,
  output logic [REG_AW-1:0] reg_wr_addr,
  output logic [DATA_W-1:0] reg_wr_data,
  output logic              busy,
  output logic              stall,
  output logic              done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]        state;
  logic              op_store;
  logic [DATA_W-1:0] cur_addr;
  logic [NREGS-1:0]  pend;
  logic [REG_AW:0]   cnt;
`ifdef LSM_BASE_WRITEBACK_EN
  logic [REG_AW-1:0] base_reg_q;
  logic [DATA_W-1:0] base_addr_q;
  logic              lm_base_hit;
`endif

  logic              in_idle, in_run, in_finish;
  logic              accept;
  logic [REG_AW-1:0] idx;
  logic [NREGS-1:0]  pend_clr;
  logic              last;

  assign in_idle   = (state == S_IDLE);
  assign in_run    = (state == S_RUN);
  assign in_finish = (state == S_FINISH);
  // flush in IDLE blocks acceptance for that cycle
  assign accept    = start & in_idle & ~flush;

  // Priority encode: lowest set bit of the pending list wins
  always_comb begin
    idx = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (pend[i]) idx = REG_AW'(i);
    end
    pend_clr = pend & ~(NREGS'(1) << idx);
    last     = (pend_clr == '0);
  end

  // Sequencer state, list walk, address and beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_store <= 1'b0;
      cur_addr <= '0;
      pend     <= '0;
      cnt      <= '0;
`ifdef LSM_BASE_WRITEBACK_EN
      base_reg_q  <= '0;
      base_addr_q <= '0;
      lm_base_hit <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_store <= is_store;
            cur_addr <= base_addr;
            pend     <= reg_list;
            cnt      <= '0;
`ifdef LSM_BASE_WRITEBACK_EN
            base_reg_q  <= base_reg;
            base_addr_q <= base_addr;
            lm_base_hit <= ~is_store & reg_list[base_reg];
`endif
            state    <= (reg_list == '0) ? S_FINISH : S_RUN;
          end
        end
        S_RUN: begin
          if (mem_ready) begin
            pend     <= pend_clr;
            cur_addr <= cur_addr + 1'b1;
            cnt      <= cnt + 1'b1;
          end
          // a beat completing alongside flush still retires above
          if (flush) begin
            state <= S_IDLE;
            pend  <= '0;
          end else if (mem_ready && last) begin
            state <= S_FINISH;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Memory, register-file and status outputs
  always_comb begin
    start_ready = in_idle;
    busy        = ~in_idle;
    stall       = busy | (start & in_idle);
    done        = in_finish & ~flush;
    mem_addr    = in_run ? cur_addr : '0;
    mem_rd      = in_run & ~op_store;
    mem_wr      = in_run & op_store;
    reg_rd_addr = in_run ? idx : '0;
    mem_wdata   = (in_run & op_store) ? reg_rd_data : '0;
    reg_wr_en   = 1'b0;
    reg_wr_addr = '0;
    reg_wr_data = '0;
    if (in_run && !op_store && mem_ready) begin
      reg_wr_en   = 1'b1;
      reg_wr_addr = idx;
      reg_wr_data = mem_rdata;
    end
`ifdef LSM_BASE_WRITEBACK_EN
    if (in_finish && !flush && (cnt != '0) && !lm_base_hit) begin
      reg_wr_en   = 1'b1;
      reg_wr_addr = base_reg_q;
      reg_wr_data = base_addr_q + DATA_W'(cnt);
    end
`endif
  end

endmodule
